reg_writeback_queue: RTL
========================

# reg_writeback_queue

Write-side buffer between the pipeline's result producers and the 32x32 register file. Accepts completed results (destination register plus data) over a valid/ready handshake, holds up to DEPTH pending writes in order, and drains one per cycle onto the register file's single write port. While results are pending, it answers two combinational bypass lookups so decode never consumes a stale register value.

## Interface
Parameters:
- DEPTH, 4, number of pending-write entries; power of two, 2..16
- XLEN, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset (one clock; reset is synchronous and active-high)
- in_valid  in  1  producer has a result
- in_ready  out  1  queue accepts this cycle
- in_rd  in  AW  destination register
- in_data  in  XLEN  result value
- wr_stall  in  1  holds the drain; no write issued this cycle
- wr_en  out  1  register-file write enable (WE3)
- wr_addr  out  AW  register-file write address (A3)
- wr_data  out  XLEN  register-file write data (WD3)
- byp_addr1, byp_addr2  in  AW  decode read addresses
- byp_hit1, byp_hit2  out  1  a pending entry targets that address
- byp_data1, byp_data2  out  XLEN  value of the youngest matching pending entry
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: circular buffer with head/tail pointers (log2 DEPTH bits, natural wrap) and an occupancy counter; entry = {rd, data}.
- Enqueue: at a rising edge with in_valid & in_ready. If in_rd == 0, the handshake completes but nothing is stored (x0 writes discarded).
- in_ready = (count != DEPTH) | wr_en; a full queue accepts when it drains in the same cycle.
- Drain: wr_en = (count != 0) & ~wr_stall; wr_addr/wr_data = head entry. Head advances at the edge where wr_en is high.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- Bypass: byp_hitN = 1 iff byp_addrN != 0 and some occupied entry has rd == byp_addrN; byp_dataN = data of the youngest (closest to tail) such entry. The head entry being written this cycle still counts (register file updates only at the edge). Entries enqueued this cycle are not visible until the next cycle. byp_dataN = 0 when no hit.
- Reset: head = tail = count = 0; wr_en = 0, in_ready = 1, byp_hit1/2 = 0, byp_data1/2 = 0. Entry storage not cleared. Reset overrides any concurrent enqueue/drain; mid-operation reset discards all pending writes.

## Timing
- All outputs combinational from registered state plus same-cycle inputs (wr_stall, byp_addr); no input-to-in_ready path except via wr_stall.
- Enqueue-to-write latency: 1 cycle minimum (accepted at edge N into an empty queue, wr_en high in cycle N+1, register file written at edge N+1).
- Throughput: one enqueue and one drain per cycle sustained.
- wr_stall held k cycles delays drain by k cycles; in_ready drops when count reaches DEPTH.
- Ordering: writes reach the register file in acceptance order; two pending writes to the same rd both drain, oldest first.

## Structure
- Shared package: XLEN, REG_AW, NUM_REGS constants and the pending-entry struct {rd, data}; the register file and pipeline stages use the same package.
- One sub-module: wbq_match (youngest-match priority selector over DEPTH entries given head, count, address), instantiated twice for the two bypass ports.

## Test plan
- Reset then enqueue {rd=5, 0xDEADBEEF}: next cycle wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, count=1; following cycle count=0, wr_en=0.
- Enqueue {rd=0, 0x1234}: in_ready=1, handshake completes, count stays 0, wr_en never asserts.
- wr_stall=1, enqueue 4 entries rd=1..4: count=4, in_ready=0; release stall with in_valid high: writes rd=1..4 in order, 5th entry accepted on first drain edge, count stays 4.
- wr_stall=1, enqueue {7,0x11} then {7,0x22}; byp_addr1=7: byp_hit1=1, byp_data1=0x22; byp_addr2=0: byp_hit2=0.
- Fill 3 entries, assert rst one cycle mid-drain: next cycle count=0, wr_en=0, byp_hit1/2=0, in_ready=1.
- Random 10k-cycle enqueue/stall traffic against a reference model: register-file write sequence and bypass values match exactly, pointers wrap correctly.

Source files
------------

// File: rtl/reg_writeback_queue_pkg.sv
// Shared register-file constants and the pending-write entry layout used by
// the writeback queue, the register file and the pipeline stages.
package reg_writeback_queue_pkg;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/wbq_match.sv
// Youngest-match selector: scans the occupied window from head (oldest) to
// tail (youngest) and returns the data of the last entry whose rd matches.
module wbq_match
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DXLEN  = reg_writeback_queue_pkg::XLEN,
  parameter int AW     = reg_writeback_queue_pkg::REG_AW,
  parameter int PW     = $clog2(DEPTH),
  parameter int CW     = $clog2(DEPTH + 1)
) (
  input  logic [AW-1:0]    rd_q   [DEPTH],
  input  logic [DXLEN-1:0] data_q [DEPTH],
  input  logic [PW-1:0]    head,
  input  logic [CW-1:0]    count,
  input  logic [AW-1:0]    addr,
  output logic             hit,
  output logic [DXLEN-1:0] data
);

  logic [PW-1:0] idx;

  // Later offsets are younger, so the last match in scan order wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if ((int'(count) > k) && (addr != '0) && (rd_q[idx] == addr)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order buffer of completed results in front of the register file write
// port, with two combinational bypass lookups over the pending writes.
module reg_writeback_queue
  import reg_writeback_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = reg_writeback_queue_pkg::XLEN,
  parameter int AW    = reg_writeback_queue_pkg::REG_AW
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [AW-1:0]              in_rd,
  input  logic [XLEN-1:0]            in_data,
  input  logic                       wr_stall,
  output logic                       wr_en,
  output logic [AW-1:0]              wr_addr,
  output logic [XLEN-1:0]            wr_data,
  input  logic [AW-1:0]              byp_addr1,
  input  logic [AW-1:0]              byp_addr2,
  output logic                       byp_hit1,
  output logic                       byp_hit2,
  output logic [XLEN-1:0]            byp_data1,
  output logic [XLEN-1:0]            byp_data2,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]   rd_q   [DEPTH];
  logic [XLEN-1:0] data_q [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            push;

  // Handshake: a result transfers at a rising edge where in_valid & in_ready;
  // in_valid may not depend on in_ready, and in_ready depends on wr_stall only.
  // A full queue still accepts when the head drains in the same cycle.
  assign wr_en    = (count != '0) & ~wr_stall;
  assign in_ready = (count != CW'(DEPTH)) | wr_en;
  assign wr_addr  = rd_q[head];
  assign wr_data  = data_q[head];

  // Writes to x0 complete the handshake but are never stored.
  assign push = in_valid & in_ready & (in_rd != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + PW'(1);
      if (wr_en) head <= head + PW'(1);
      count <= count + CW'(push) - CW'(wr_en);
    end
  end

  // Storage is never cleared; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[tail]   <= in_rd;
      data_q[tail] <= in_data;
    end
  end

  wbq_match #(.DEPTH(DEPTH), .DXLEN(XLEN), .AW(AW), .PW(PW), .CW(CW)) u_match1 (
    .rd_q   (rd_q),
    .data_q (data_q),
    .head   (head),
    .count  (count),
    .addr   (byp_addr1),
    .hit    (byp_hit1),
    .data   (byp_data1)
  );

  wbq_match #(.DEPTH(DEPTH), .DXLEN(XLEN), .AW(AW), .PW(PW), .CW(CW)) u_match2 (
    .rd_q   (rd_q),
    .data_q (data_q),
    .head   (head),
    .count  (count),
    .addr   (byp_addr2),
    .hit    (byp_hit2),
    .data   (byp_data2)
  );

endmodule
